// File: rtl/gray_disp_pkg.sv
// Shared types, segment constants and Gray decoding for the gray_bcd_display demo.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high here;
// any board-level polarity inversion happens in the top.
package gray_disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'b0111111; // abcdef
  localparam seg7_t SEG_1     = 7'b0000110; // bc
  localparam seg7_t SEG_2     = 7'b1011011; // abdeg
  localparam seg7_t SEG_3     = 7'b1001111; // abcdg
  localparam seg7_t SEG_4     = 7'b1100110; // bcfg
  localparam seg7_t SEG_5     = 7'b1101101; // acdfg
  localparam seg7_t SEG_6     = 7'b1111101; // acdefg
  localparam seg7_t SEG_7     = 7'b0000111; // abc
  localparam seg7_t SEG_8     = 7'b1111111; // abcdefg
  localparam seg7_t SEG_9     = 7'b1101111; // abcdfg
  localparam seg7_t SEG_BLANK = 7'b0000000;

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-high 7-segment decoder; codes above 9 blank the digit.
module seg7_decoder
  import gray_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg7_t      seg_o
);

  // Map one decimal digit onto its segment pattern.
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/gray_bcd_display.sv
// Board top for the tang9k Gray-input demo: synchronizes four Gray switches,
// decodes to binary, shows it on 4 LEDs and as decimal on two 7-segment digits.
// Optional macro SEG_COMMON_ANODE_EN inverts all 14 segment outputs for
// common-anode displays (reset then drives them high = blank); LEDs unaffected.
// SYNC_STAGES must be at least 2.
module gray_bcd_display
  import gray_disp_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ag,
  input  logic       bg,
  input  logic       cg,
  input  logic       dg,
  output logic [3:0] led,
  output logic       au, bu, cu, du, eu, fu, gu,
  output logic       ad, bd, cd, dd, ed, fd, gd
);

`ifdef SEG_COMMON_ANODE_EN
  localparam seg7_t SEG_OFF = ~SEG_BLANK;
`else
  localparam seg7_t SEG_OFF = SEG_BLANK;
`endif

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] gray;
  logic [3:0] bin;
  logic [3:0] units;
  logic [3:0] tens;
  seg7_t      useg_raw;
  seg7_t      dseg_raw;
  logic [3:0] led_d, led_q;
  seg7_t      useg_d, useg_q;
  seg7_t      dseg_d, dseg_q;

  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
    if (s == 0) begin : g_first
      // First synchronizer flop samples the raw switch pins.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q[0] <= 4'b0000;
        else        sync_q[0] <= {ag, bg, cg, dg};
      end
    end else begin : g_rest
      // Later flops give metastability time to resolve.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q[s] <= 4'b0000;
        else        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign gray = sync_q[SYNC_STAGES-1];

  // Decode Gray to binary and split into tens/units digits.
  always_comb begin
    bin = gray2bin(gray);
    if (bin >= 4'd10) begin
      tens  = 4'd1;
      units = bin - 4'd10;
    end else begin
      tens  = 4'd0;
      units = bin;
    end
  end

  seg7_decoder u_units (.bcd_i(units), .seg_o(useg_raw));
  seg7_decoder u_tens  (.bcd_i(tens),  .seg_o(dseg_raw));

  // Apply board segment polarity ahead of the output register.
  always_comb begin
    led_d = bin;
`ifdef SEG_COMMON_ANODE_EN
    useg_d = ~useg_raw;
    dseg_d = ~dseg_raw;
`else
    useg_d = useg_raw;
    dseg_d = dseg_raw;
`endif
  end

  // LEDs and both digits update on the same edge so digits never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q  <= 4'b0000;
      useg_q <= SEG_OFF;
      dseg_q <= SEG_OFF;
    end else begin
      led_q  <= led_d;
      useg_q <= useg_d;
      dseg_q <= dseg_d;
    end
  end

  assign led = led_q;
  assign {gu, fu, eu, du, cu, bu, au} = useg_q;
  assign {gd, fd, ed, dd, cd, bd, ad} = dseg_q;

endmodule

// File: tb/tb_gray_bcd_display.sv
// Scoreboard bench for gray_bcd_display: stimulus pushes expected displays,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_gray_bcd_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ag, bg, cg, dg;
  logic [3:0] led;
  logic       au, bu, cu, du, eu, fu, gu;
  logic       ad, bd, cd, dd, ed, fd, gd;

  typedef struct {
    string      name;
    logic [3:0] led;
    logic [6:0] u;
    logic [6:0] d;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  gray_bcd_display #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ag(ag), .bg(bg), .cg(cg), .dg(dg),
    .led(led),
    .au(au), .bu(bu), .cu(cu), .du(du), .eu(eu), .fu(fu), .gu(gu),
    .ad(ad), .bd(bd), .cd(cd), .dd(dd), .ed(ed), .fd(fd), .gd(gd)
  );

  always #5 clk = ~clk;

  // Board polarity as seen on the pins.
  function automatic logic [6:0] pol(input logic [6:0] s);
`ifdef SEG_COMMON_ANODE_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  // Hand-written units pattern {g..a} for each value 0..15.
  function automatic logic [6:0] u_pat(input int v);
    case (v)
      0, 10: return 7'b0111111;
      1, 11: return 7'b0000110;
      2, 12: return 7'b1011011;
      3, 13: return 7'b1001111;
      4, 14: return 7'b1100110;
      5, 15: return 7'b1101101;
      6:     return 7'b1111101;
      7:     return 7'b0000111;
      8:     return 7'b1111111;
      9:     return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] d_pat(input int v);
    return (v >= 10) ? 7'b0000110 : 7'b0111111;
  endfunction

  task automatic push(input string name, input logic [3:0] l,
                      input logic [6:0] u, input logic [6:0] d);
    exp_t x;
    x.name = name; x.led = l; x.u = u; x.d = d;
    sb_q.push_back(x);
  endtask

  task automatic push_val(input string name, input int v);
    push(name, v[3:0], pol(u_pat(v)), pol(d_pat(v)));
  endtask

  task automatic set_gray(input logic [3:0] g);
    {ag, bg, cg, dg} = g;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %b expected %b", name, field, act, exp);
  endtask

  // Monitor: compare every expectation queued since the last falling edge.
  always @(negedge clk) begin
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      cmp(e.name, "led", {3'b000, led}, {3'b000, e.led});
      cmp(e.name, "units", {gu, fu, eu, du, cu, bu, au}, e.u);
      cmp(e.name, "tens",  {gd, fd, ed, dd, cd, bd, ad}, e.d);
    end
  end

  initial begin
    rst_n = 1'b0;
    set_gray(4'b1010);
    settle(2);
    push("reset", 4'b0000, pol(7'b0000000), pol(7'b0000000));

    @(negedge clk);
    rst_n = 1'b1;
    set_gray(4'b0000);
    settle(3);
    push_val("post_reset", 0);

    for (int i = 0; i < 16; i++) begin
      set_gray(4'(i ^ (i >> 1)));
      settle(5);
      push_val($sformatf("sweep%0d", i), i);
    end

    // Latency: value 0 -> 1 appears on the third edge after the change.
    set_gray(4'b0000);
    settle(5);
    set_gray(4'b0001);
    settle(1); push_val("lat_e1", 0);
    settle(1); push_val("lat_e2", 0);
    settle(1); push_val("lat_e3", 1);

    // Asynchronous reset between edges while 15 is shown.
    set_gray(4'b1000);
    settle(5);
    push_val("pre_async", 15);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 push("async_rst", 4'b0000, pol(7'b0000000), pol(7'b0000000));
    @(negedge clk);
    #1 rst_n = 1'b1;
    settle(2); push_val("rel_e2", 0);
    settle(1); push_val("rel_e3", 15);

    settle(2);
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gray_bcd_display.md
Name: gray_bcd_display

Overview:
- Reads a 4-bit Gray-coded value from four switch/pin inputs and converts it to binary.
- Shows the binary value on 4 LEDs.
- Shows the decimal value (0..15) on two common-cathode 7-segment digits: units and tens.
- Board-level top for the tang9k Gray-input demo. Inputs are synchronized and all outputs are registered.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in each input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ag  input  1  Gray bit 3 (MSB)
- bg  input  1  Gray bit 2
- cg  input  1  Gray bit 1
- dg  input  1  Gray bit 0 (LSB)
- led  output  4  decoded binary value; led[3]=MSB; active-high
- au,bu,cu,du,eu,fu,gu  output  1 each  units-digit segments a..g; active-high
- ad,bd,cd,dd,ed,fd,gd  output  1 each  tens-digit segments a..g; active-high

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (rst_n). Assertion takes effect immediately; deassertion is sampled on the clk rising edge.
  - During reset, synchronizers clear to 0, led=0000, and all 14 segment outputs = 0 (both digits blank).
- Synchronizer: each of ag..dg passes through SYNC_STAGES flops and forms g[3:0] = {ag,bg,cg,dg}.
- Gray-to-binary conversion (combinational on g):
  - b[3]=g[3]
  - b[i]=b[i+1]^g[i] for i = 2..0
- BCD split (combinational):
  - b<10: tens=0, units=b.
  - b>=10: tens=1, units=b-10.
- Segment encoding, bits a..g per digit:
  - 0 → abcdef
  - 1 → bc
  - 2 → abdeg
  - 3 → abcdg
  - 4 → bcfg
  - 5 → acdfg
  - 6 → acdefg
  - 7 → abc
  - 8 → abcdefg
  - 9 → abcdfg
- Tens digit displays "0" (abcdef) for values 0..9; no leading-zero blanking.
- Output register: led, units segments and tens segments are registered on the same clk edge and always update together, so no glitches appear between digits.
- Latency: an input change appears on the outputs SYNC_STAGES+1 rising edges later (3 with the default).
- Inputs are static switches. No debounce; the synchronizer only guards metastability. Multi-bit input changes may show one intermediate value for a single cycle, which is acceptable.
- All 16 Gray codes are legal. There are no invalid or error states and no FSM.

Optional Feature:
- Macro: SEG_COMMON_ANODE_EN.
- Defined: all 14 segment outputs are inverted (active-low, for common-anode displays). During reset all segments = 1 (blank).
- Undefined: segments are active-high as described above.
- led polarity is unaffected either way.

Decomposition:
- Package gray_disp_pkg:
  - typedef seg7_t as logic [6:0] with bit order {g,f,e,d,c,b,a}.
  - Localparam constants SEG_0..SEG_9 and SEG_BLANK.
  - Function gray2bin(logic [3:0]).
- One sub-module, seg7_decoder: combinational 4-bit BCD in, seg7_t out. Instantiated twice (units, tens); codes above 9 map to SEG_BLANK.
- Synchronizer stays inline as a generate loop.

Test Plan:
- Reset: hold rst_n=0 with any inputs → led=0000 and all segments 0. Release, then apply Gray 0000 → after 3 clocks led=0000, U=abcdef, D=abcdef.
- Sweep 0..9: drive {ag,bg,cg,dg}=i^(i>>1) for 50 ns each. Example: i=5 → Gray 0111 → led=0101, U=acdfg, D=abcdef. Example: i=9 → Gray 1101 → led=1001, U=abcdfg, D=abcdef.
- Sweep 10..15: Gray 1111 (10) → led=1010, U=abcdef, D=bc. Gray 1000 (15) → led=1111, U=acdfg, D=bc.
- Latency: toggle dg from 0 to 1 (value 0→1) right after a clk edge → outputs still show 0 for 2 edges, show led=0001 and U=bc on the 3rd edge.
- Async reset mid-operation: with value 15 displayed, pull rst_n low between clock edges → outputs clear immediately without waiting for a clk edge. Release → value reappears 3 clocks later.
- SEG_COMMON_ANODE_EN defined: value 8 → all segment outputs 0 for U, D segments = 1000000 (only g high). Reset → all segments 1.
